// File: rtl/key_debounce_multi.sv
// Multi-channel front-panel key conditioner: per-key synchroniser, debouncer and
// hold timer producing level, press, release, long-press and auto-repeat pulses.

module key_debounce_lane #(
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned LONG_MAX   = 49_999_999,
    parameter int unsigned REPEAT_MAX = 9_999_999,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic button_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    localparam int unsigned DW   = $clog2(CNT_MAX + 1);
    localparam int unsigned HMAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_e;

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    state_e        state_q, state_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;
    logic          pressed_s, flip;

    // Synchroniser presets to the released level so reset release never looks like a press.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= button_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ~sync2_q;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        flip   = 1'b0;
        if (pressed_s != deb_q) begin
            if (dcnt_q == DW'(CNT_MAX - 1)) begin
                flip  = 1'b1;
                deb_d = pressed_s;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    // A debounced flip out of HOLD/RPT is always a release, and it pre-empts any threshold pulse.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flip) begin
                    press_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flip) begin
                    release_d = 1'b1;
                    hcnt_d    = '0;
                    state_d   = IDLE;
                end else if (hcnt_q == HW'(LONG_MAX - 1)) begin
                    long_d  = 1'b1;
                    hcnt_d  = '0;
                    state_d = RPT;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            RPT: begin
                if (flip) begin
                    release_d = 1'b1;
                    hcnt_d    = '0;
                    state_d   = IDLE;
                end else if (hcnt_q == HW'(REPEAT_MAX - 1)) begin
                    repeat_d = REPEAT_EN;
                    hcnt_d   = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            deb_q     <= 1'b0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign key_state   = deb_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;
endmodule

module key_debounce_multi #(
    parameter int unsigned KEY_NUM    = 4,
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned LONG_MAX   = 49_999_999,
    parameter int unsigned REPEAT_MAX = 9_999_999,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] button_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat
);
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_lane
        key_debounce_lane #(
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX),
            .REPEAT_MAX (REPEAT_MAX),
            .REPEAT_EN  (REPEAT_EN)
        ) u_lane (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .button_in   (button_in[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench: an event-level key model predicts every output pulse; monitors
// compare two DUT copies (auto-repeat enabled / disabled) as their pulses appear.

module tb_key_debounce_multi;
    localparam int CNT  = 4;
    localparam int LONG = 10;
    localparam int REP  = 3;

    typedef struct {
        int         cyc;
        logic [3:0] st, pr, rl, lg, rp;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pins = 4'hF;
    logic [3:0] st_a, pr_a, rl_a, lg_a, rp_a;
    logic [3:0] st_b, pr_b, rl_b, lg_b, rp_b;

    rec_t qa[$];
    rec_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_edge = 0;

    logic [3:0] m_deb;
    int         m_run[4];
    int         m_pedge[4];

    always #5 clk = ~clk;

    key_debounce_multi #(.KEY_NUM(4), .CNT_MAX(CNT), .LONG_MAX(LONG), .REPEAT_MAX(REP),
                         .REPEAT_EN(1'b1)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .button_in(pins), .key_state(st_a), .key_press(pr_a),
        .key_release(rl_a), .key_long(lg_a), .key_repeat(rp_a));

    key_debounce_multi #(.KEY_NUM(4), .CNT_MAX(CNT), .LONG_MAX(LONG), .REPEAT_MAX(REP),
                         .REPEAT_EN(1'b0)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .button_in(pins), .key_state(st_b), .key_press(pr_b),
        .key_release(rl_b), .key_long(lg_b), .key_repeat(rp_b));

    task automatic model_reset();
        m_deb = '0;
        for (int c = 0; c < 4; c++) begin
            m_run[c]   = 0;
            m_pedge[c] = 0;
        end
    endtask

    // Pin level sampled at edge e becomes visible to the debouncer two edges later.
    task automatic model_step(input logic [3:0] p, input int e);
        rec_t r;
        int   t;
        int   d;
        logic ev;
        t    = e + 2;
        r.cyc = t;
        r.st = '0; r.pr = '0; r.rl = '0; r.lg = '0; r.rp = '0;
        for (int c = 0; c < 4; c++) begin
            ev = 1'b0;
            if ((~p[c]) != m_deb[c]) begin
                m_run[c]++;
                if (m_run[c] == CNT) begin
                    m_deb[c] = ~m_deb[c];
                    m_run[c] = 0;
                    ev = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
            if (ev && m_deb[c]) begin
                r.pr[c] = 1'b1;
                m_pedge[c] = t;
            end else if (ev) begin
                r.rl[c] = 1'b1;
            end else if (m_deb[c]) begin
                d = t - m_pedge[c];
                if (d == LONG) r.lg[c] = 1'b1;
                else if (d > LONG && (d - LONG) % REP == 0) r.rp[c] = 1'b1;
            end
            r.st[c] = m_deb[c];
        end
        if (|{r.pr, r.rl, r.lg, r.rp}) qa.push_back(r);
        r.rp = '0;
        if (|{r.pr, r.rl, r.lg}) qb.push_back(r);
    endtask

    task automatic check_dut(input int d);
        logic [3:0] st, pr, rl, lg, rp;
        logic       any, has;
        rec_t       f;
        if (d == 0) begin
            st = st_a; pr = pr_a; rl = rl_a; lg = lg_a; rp = rp_a;
            has = (qa.size() > 0) && (qa[0].cyc == cur_edge);
            if (has) f = qa.pop_front();
        end else begin
            st = st_b; pr = pr_b; rl = rl_b; lg = lg_b; rp = rp_b;
            has = (qb.size() > 0) && (qb[0].cyc == cur_edge);
            if (has) f = qb.pop_front();
        end
        any = |{pr, rl, lg, rp};
        if (has || any) begin
            checks++;
            if (!has) begin
                errors++;
                $display("FAIL unexpected_pulse dut%0d edge %0d: got st=%h pr=%h rl=%h lg=%h rp=%h, expected no pulse",
                         d, cur_edge, st, pr, rl, lg, rp);
            end else if ({f.st, f.pr, f.rl, f.lg, f.rp} !== {st, pr, rl, lg, rp}) begin
                errors++;
                $display("FAIL pulse dut%0d edge %0d: got st=%h pr=%h rl=%h lg=%h rp=%h, expected st=%h pr=%h rl=%h lg=%h rp=%h",
                         d, cur_edge, st, pr, rl, lg, rp, f.st, f.pr, f.rl, f.lg, f.rp);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check_dut(0);
            check_dut(1);
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({st_a, pr_a, rl_a, lg_a, rp_a, st_b, pr_b, rl_b, lg_b, rp_b} !== '0) begin
            errors++;
            $display("FAIL %s: got A=%h B=%h, expected all zero", name,
                     {st_a, pr_a, rl_a, lg_a, rp_a}, {st_b, pr_b, rl_b, lg_b, rp_b});
        end
    endtask

    task automatic do_reset(input int n, input logic [3:0] p);
        @(negedge clk);
        rst  = 1'b1;
        pins = p;
        qa.delete();
        qb.delete();
        model_reset();
        #1 check_zero("reset_assert");
        repeat (n) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        rst      = 1'b0;
        cur_edge = 1;
        model_step(pins, cur_edge);
    endtask

    task automatic cyc(input logic [3:0] p, input int n);
        repeat (n) begin
            @(negedge clk);
            pins = p;
            cur_edge++;
            model_step(p, cur_edge);
        end
    endtask

    int         rem[4];
    logic [3:0] rp_pins;

    initial begin
        model_reset();
        // Reset with all keys released, then idle.
        do_reset(20, 4'hF);
        cyc(4'hF, 6);
        // Key 0 held into auto-repeat, then reset while held: re-debounced as a new press.
        cyc(4'b1110, 30);
        do_reset(3, 4'b1110);
        cyc(4'b1110, 12);
        cyc(4'hF, 10);
        // Key 1 bouncing faster than the debounce window.
        repeat (10) begin
            cyc(4'b1101, 3);
            cyc(4'hF, 2);
        end
        cyc(4'hF, 6);
        // Key 2 released so its debounced release lands on the long-press threshold.
        cyc(4'b1011, 10);
        cyc(4'hF, 15);
        // Keys 0 and 3 pressed together.
        cyc(4'b0110, 25);
        cyc(4'hF, 10);
        // Random key activity with a mix of bounces and long holds.
        rp_pins = 4'hF;
        for (int c = 0; c < 4; c++) rem[c] = 1;
        for (int i = 0; i < 700; i++) begin
            for (int c = 0; c < 4; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    rp_pins[c] = ~rp_pins[c];
                    rem[c] = (rp_pins[c] == 1'b0) ? int'($urandom_range(1, 30))
                                                  : int'($urandom_range(1, 12));
                end
            end
            if (i == 350) do_reset(2, rp_pins);
            else cyc(rp_pins, 1);
        end
        cyc(4'hF, 12);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL drain_a: got %0d pending pulses, expected 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL drain_b: got %0d pending pulses, expected 0", qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
